// File: rtl/contrast_pipe.sv
`default_nettype none
// ============================================================================
// Module   : contrast_pipe
// Brief    : Two-stage per-channel contrast gain around mid-grey, with the
//            level/enable settings changed only at frame boundaries.
// Revision : 1.0  initial release
// ============================================================================
module contrast_pipe #(
    parameter int DW   = 8,
    parameter int CH   = 3,
    parameter int LW   = 4,
    parameter int FRAC = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_en,
    input  logic               inc,
    input  logic               dec,
    input  logic [CH*DW-1:0]   pix_in,
    input  logic               pix_in_valid,
    output logic [CH*DW-1:0]   pix_out,
    output logic               pix_out_valid,
    output logic [LW-1:0]      level,
    output logic               active
);

    localparam int PW = DW + LW + 1;
    localparam int SW = DW + LW + 2;

    localparam logic [DW:0]   c_MID       = {2'b01, {(DW-1){1'b0}}};
    localparam logic [LW-1:0] c_LVL_MAX   = {LW{1'b1}};
    localparam logic [LW-1:0] c_LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] c_LVL_UNITY = LW'(1 << FRAC);

    logic [LW-1:0]    r_level;
    logic             r_active;
    logic             r_pend_inc;
    logic             r_pend_dec;

    logic             r_s1_valid;
    logic             r_s1_active;
    logic [CH*DW-1:0] r_s1_pix;
    logic [CH*PW-1:0] r_s1_p;
    logic [CH*DW-1:0] r_out;
    logic             r_out_valid;

    logic [CH*PW-1:0] w_prod;
    logic [CH*DW-1:0] w_adj;
    logic             w_inc_any;
    logic             w_dec_any;

    // Requests arriving in the same cycle as the strobe count toward it.
    assign w_inc_any = r_pend_inc | inc;
    assign w_dec_any = r_pend_dec | dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level    <= c_LVL_UNITY;
            r_active   <= 1'b0;
            r_pend_inc <= 1'b0;
            r_pend_dec <= 1'b0;
        end else if (frame_en) begin
            r_active   <= enable;
            r_pend_inc <= 1'b0;
            r_pend_dec <= 1'b0;
            if (r_active) begin
                if (w_inc_any && !w_dec_any && (r_level != c_LVL_MAX))
                    r_level <= r_level + c_LVL_ONE;
                else if (w_dec_any && !w_inc_any && (r_level != '0))
                    r_level <= r_level - c_LVL_ONE;
            end
        end else if (r_active) begin
            if (inc)
                r_pend_inc <= 1'b1;
            if (dec)
                r_pend_dec <= 1'b1;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [DW:0]   w_d;
        logic signed [PW-1:0] w_d_ext;
        logic signed [PW-1:0] w_lvl_ext;
        logic signed [PW-1:0] w_p;
        logic signed [PW-1:0] w_shift;
        logic signed [SW-1:0] w_s;
        logic [DW-1:0]        w_clamped;

        assign w_d       = $signed({1'b0, pix_in[c*DW +: DW]}) - $signed(c_MID);
        assign w_d_ext   = {{LW{w_d[DW]}}, w_d};
        assign w_lvl_ext = {{(DW+1){1'b0}}, r_level};
        assign w_p       = w_d_ext * w_lvl_ext;
        assign w_prod[c*PW +: PW] = w_p;

        // Arithmetic shift floors toward minus infinity before re-centring.
        assign w_shift = $signed(r_s1_p[c*PW +: PW]) >>> FRAC;
        assign w_s     = {w_shift[PW-1], w_shift} + {{(LW+1){1'b0}}, c_MID};

        always_comb begin
            if (w_s[SW-1])
                w_clamped = '0;
            else if (|w_s[SW-2:DW])
                w_clamped = '1;
            else
                w_clamped = w_s[DW-1:0];
        end

        assign w_adj[c*DW +: DW] = w_clamped;
    end

    // Settings are frozen into stage 1 alongside the pixel so a pixel never
    // sees a mix of old and new level/enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_p      <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            r_s1_valid  <= pix_in_valid;
            r_out_valid <= r_s1_valid;
            if (pix_in_valid) begin
                r_s1_active <= r_active;
                r_s1_pix    <= pix_in;
                r_s1_p      <= w_prod;
            end
            if (r_s1_valid)
                r_out <= r_s1_active ? w_adj : r_s1_pix;
        end
    end

    assign pix_out       = r_out;
    assign pix_out_valid = r_out_valid;
    assign level         = r_level;
    assign active        = r_active;

endmodule
`default_nettype wire

// File: tb/tb_contrast_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_contrast_pipe
// Brief    : Scoreboard bench for contrast_pipe with a behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_contrast_pipe;

    localparam int DW   = 8;
    localparam int CH   = 3;
    localparam int LW   = 4;
    localparam int FRAC = 3;
    localparam int PXW  = CH * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           frame_en = 1'b0;
    logic           inc = 1'b0;
    logic           dec = 1'b0;
    logic [PXW-1:0] pix_in = '0;
    logic           pix_in_valid = 1'b0;
    logic [PXW-1:0] pix_out;
    logic           pix_out_valid;
    logic [LW-1:0]  level;
    logic           active;

    contrast_pipe #(.DW(DW), .CH(CH), .LW(LW), .FRAC(FRAC)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .frame_en      (frame_en),
        .inc           (inc),
        .dec           (dec),
        .pix_in        (pix_in),
        .pix_in_valid  (pix_in_valid),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .level         (level),
        .active        (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    int             m_level = 8;
    bit             m_active = 1'b0;
    bit             m_pi = 1'b0;
    bit             m_pd = 1'b0;
    bit             en_req = 1'b0;
    logic [PXW-1:0] last_out = '0;

    typedef struct {
        logic [PXW-1:0] data;
        int             due;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [PXW-1:0] pix3(input int r, input int g, input int b);
        logic [7:0] rr, gg, bb;
        rr = 8'(r);
        gg = 8'(g);
        bb = 8'(b);
        return {bb, gg, rr};
    endfunction

    function automatic logic [PXW-1:0] model_pix(input logic [PXW-1:0] px, input int lvl, input bit act);
        logic [PXW-1:0] res;
        int d, p, s;
        res = px;
        if (act) begin
            for (int c = 0; c < CH; c++) begin
                d = int'(px[c*DW +: DW]) - (1 << (DW - 1));
                p = d * lvl;
                s = (1 << (DW - 1)) + (p >>> FRAC);
                if (s < 0)
                    s = 0;
                else if (s > (1 << DW) - 1)
                    s = (1 << DW) - 1;
                res[c*DW +: DW] = s[DW-1:0];
            end
        end
        return res;
    endfunction

    task automatic drive(input bit fr, input bit i, input bit d, input bit v, input logic [PXW-1:0] px);
        bit up, dn;
        @(posedge clk);
        #1;
        check_val("level", 64'(level), 64'(m_level));
        check_val("active", 64'(active), 64'(m_active));
        enable       = en_req;
        frame_en     = fr;
        inc          = i;
        dec          = d;
        pix_in_valid = v;
        pix_in       = px;
        if (v)
            sb.push_back('{model_pix(px, m_level, m_active), cyc + 2});
        if (fr) begin
            up = m_pi | (m_active & i);
            dn = m_pd | (m_active & d);
            if (m_active) begin
                if (up && !dn && m_level < (1 << LW) - 1)
                    m_level++;
                else if (dn && !up && m_level > 0)
                    m_level--;
            end
            m_active = en_req;
            m_pi = 1'b0;
            m_pd = 1'b0;
        end else if (m_active) begin
            m_pi |= i;
            m_pd |= d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_out_valid) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_valid", 64'(pix_out_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("pix_out", 64'(pix_out), 64'(e.data));
                    check_val("latency", 64'(cyc), 64'(e.due));
                    last_out = pix_out;
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check_val("missing_valid", 64'(pix_out_valid), 64'(1));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check_val("rst_level", 64'(level), 64'(8));
        check_val("rst_active", 64'(active), 64'(0));
        check_val("rst_valid", 64'(pix_out_valid), 64'(0));
        check_val("rst_pix", 64'(pix_out), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(2);

        // Enable at a boundary, unity gain passes the pixel unchanged.
        en_req = 1'b1;
        drive(1, 0, 0, 0, '0);
        drive(0, 0, 0, 1, pix3(200, 128, 100));
        idle(3);
        check_val("unity_pix", 64'(last_out), 64'(pix3(200, 128, 100)));
        check_val("unity_active", 64'(active), 64'(1));

        repeat (4) begin
            drive(0, 1, 0, 0, '0);
            drive(1, 0, 0, 0, '0);
        end
        drive(0, 0, 0, 1, pix3(200, 100, 128));
        idle(3);
        check_val("lvl12", 64'(level), 64'(12));
        check_val("lvl12_pix", 64'(last_out), 64'(pix3(236, 86, 128)));

        // Requests in the same cycle as the strobe; saturation at the top.
        repeat (3) drive(1, 1, 0, 0, '0);
        drive(0, 0, 0, 1, pix3(255, 0, 128));
        idle(3);
        check_val("lvl15", 64'(level), 64'(15));
        check_val("clamp_pix", 64'(last_out), 64'(pix3(255, 0, 128)));
        drive(0, 1, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
        idle(1);
        check_val("sat_hi", 64'(level), 64'(15));

        repeat (16) drive(1, 0, 1, 0, '0);
        drive(0, 0, 0, 1, pix3(255, 0, 128));
        idle(3);
        check_val("sat_lo", 64'(level), 64'(0));
        check_val("lvl0_pix", 64'(last_out), 64'(pix3(128, 128, 128)));

        repeat (8) drive(1, 1, 0, 0, '0);
        drive(0, 1, 0, 0, '0);
        drive(0, 0, 1, 0, '0);
        drive(1, 0, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
        idle(1);
        check_val("both_cancel", 64'(level), 64'(8));

        // A pending inc alone must not move the level before the boundary.
        drive(0, 1, 0, 0, '0);
        idle(4);
        check_val("no_frame", 64'(level), 64'(8));
        drive(0, 0, 0, 1, pix3(200, 100, 128));
        idle(3);
        check_val("no_frame_pix", 64'(last_out), 64'(pix3(200, 100, 128)));
        drive(1, 0, 0, 0, '0);
        idle(1);
        check_val("pend_applied", 64'(level), 64'(9));

        repeat (3) drive(1, 1, 0, 0, '0);
        en_req = 1'b0;
        drive(0, 0, 0, 1, pix3(200, 100, 128));
        idle(3);
        check_val("pre_disable_pix", 64'(last_out), 64'(pix3(236, 86, 128)));
        drive(1, 0, 0, 0, '0);
        drive(0, 1, 0, 0, '0);
        drive(0, 1, 0, 0, '0);
        drive(0, 0, 0, 1, pix3(200, 100, 128));
        idle(3);
        check_val("bypass_pix", 64'(last_out), 64'(pix3(200, 100, 128)));
        check_val("bypass_active", 64'(active), 64'(0));
        drive(1, 0, 0, 0, '0);
        idle(1);
        check_val("held_level", 64'(level), 64'(12));
        en_req = 1'b1;
        drive(1, 0, 0, 0, '0);
        drive(0, 0, 0, 1, pix3(200, 100, 128));
        idle(3);
        check_val("reenable_lvl", 64'(level), 64'(12));
        check_val("reenable_pix", 64'(last_out), 64'(pix3(236, 86, 128)));

        for (int k = 0; k < 80; k++) begin
            en_req = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), PXW'($urandom));
        end
        idle(4);

        // Asynchronous reset with two pixels in flight.
        en_req = 1'b1;
        drive(0, 0, 0, 1, pix3(10, 20, 30));
        drive(0, 0, 0, 1, pix3(40, 50, 60));
        #1 rst = 1'b1;
        sb.delete();
        m_level = 8;
        m_active = 1'b0;
        m_pi = 1'b0;
        m_pd = 1'b0;
        pix_in_valid = 1'b0;
        frame_en = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(pix_out_valid), 64'(0));
        check_val("mid_rst_level", 64'(level), 64'(8));
        check_val("mid_rst_active", 64'(active), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        idle(5);
        check_val("post_rst_valid", 64'(pix_out_valid), 64'(0));
        drive(1, 0, 0, 0, '0);
        drive(0, 0, 0, 1, pix3(200, 100, 128));
        idle(4);
        check_val("post_rst_pix", 64'(last_out), 64'(pix3(200, 100, 128)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contrast_pipe.md
CONTRAST_PIPE -- requirements
Module: contrast_pipe

Interface
REQ-001 Parameter DW, default 8: bits per colour channel.
REQ-002 Parameter CH, default 3: number of channels processed in parallel.
REQ-003 Parameter LW, default 4: contrast level width; level range 0..2^LW-1.
REQ-004 Parameter FRAC, default 3: fractional bits of level; unity gain = 2^FRAC; legal only if 2^FRAC <= 2^LW-1.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  requested master enable, sampled only at frame boundary.
REQ-008 frame_en  in  1  single-cycle frame-boundary strobe.
REQ-009 inc  in  1  increase-contrast request pulse.
REQ-010 dec  in  1  decrease-contrast request pulse.
REQ-011 pix_in  in  CH*DW  packed channels, channel 0 in bits [DW-1:0].
REQ-012 pix_in_valid  in  1  pix_in qualifier.
REQ-013 pix_out  out  CH*DW  adjusted pixel, same packing.
REQ-014 pix_out_valid  out  1  pix_out qualifier.
REQ-015 level  out  LW  contrast level currently applied.
REQ-016 active  out  1  enable state currently applied.

Function
REQ-017 Midpoint MID = 2^(DW-1); per channel d = in - MID as signed DW+1 bits.
REQ-018 Product p = d * level, signed, DW+LW+1 bits, no overflow.
REQ-019 s = MID + (p >>> FRAC), arithmetic shift (floor toward minus infinity), full-width signed sum.
REQ-020 Output clamp: s < 0 -> 0; s > 2^DW-1 -> 2^DW-1; else s[DW-1:0].
REQ-021 Pipeline: stage 1 registers p per channel plus valid; stage 2 registers clamped result plus valid; latency exactly 2 cycles, throughput 1 pixel/cycle, no stall.
REQ-022 pix_out_valid = pix_in_valid delayed 2 cycles; pix_out content don't-care when valid low.
REQ-023 When active=0, pix_out = pix_in delayed 2 cycles, unmodified, same latency and valid timing.
REQ-024 active and level used by a pixel are those in effect when it enters stage 1; no pixel sees mixed settings.
REQ-025 Request latch: while active=1, inc sets pend_inc and dec sets pend_dec; flags sticky until next frame_en; while active=0 inc/dec ignored and not latched.
REQ-026 Requests asserted in the same cycle as frame_en are included in that frame_en's update.
REQ-027 At frame_en with active=1: pend_inc only -> level+1 saturating at 2^LW-1; pend_dec only -> level-1 saturating at 0; both or neither -> level unchanged.
REQ-028 At frame_en both pend flags cleared regardless of outcome; level changes by at most 1 per frame.
REQ-029 At frame_en, active <= enable; level and pend flags updated in same cycle; new values take effect next cycle.
REQ-030 Level and active never change except at frame_en or reset; level retained while inactive.
REQ-031 frame_en in consecutive cycles: each strobe is an independent boundary.

Reset
REQ-032 rst asserted asynchronously forces: level = 2^FRAC, active = 0, pend_inc = pend_dec = 0, both stage valids = 0, pix_out = 0.
REQ-033 Reset mid-frame discards in-flight pixels; pix_out_valid low on cycle after release until new pixels traverse both stages.
REQ-034 After release, active stays 0 until first frame_en sampling enable=1.

Verification
REQ-035 Reset, enable=1, frame_en pulse, then pix_in R/G/B = 200/128/100 valid -> 2 cycles later 200/128/100 (unity level 8), active=1.
REQ-036 inc pulse then frame_en, repeated 4 times -> level 12; pix_in 200/100/128 -> 236/86/128.
REQ-037 inc to level 15, pix_in 255/0/128 -> 255/0/128 via clamp (raw 366/-112/128); extra inc+frame_en keeps level 15; dec from 0 keeps 0 with output 128/128/128.
REQ-038 inc and dec both pulsed before one frame_en -> level unchanged, pend flags cleared; inc without frame_en -> level and output unchanged.
REQ-039 enable=0 mid-frame -> processing continues until frame_en, then pix_in 200 -> 200 at latency 2, inc ignored, level held; re-enable at next frame_en restores prior level.
REQ-040 rst asserted with 2 valid pixels in flight -> pix_out_valid low next cycle, level 8, active 0, no stale pixel emitted after release.
